// File: rtl/temp_sensor_scheduler_pkg.sv
// Shared definitions for the temperature sensor scheduler: channel and
// datapath widths, default tuning parameters, FSM states and the
// round-robin channel picker.
package temp_sensor_scheduler_pkg;

  localparam int NUM_CH             = 4;
  localparam int SENSOR_W           = 4;
  localparam int TEMP_W             = 8;
  localparam int BASE_W             = 5;
  localparam int CH_W               = $clog2(NUM_CH);
  localparam int DEFAULT_SHIFT      = 3;
  localparam int DEFAULT_ALARM_HYST = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } stateT;

  // Returns {found, index}. The search starts one past the last served
  // channel, so the channel just served has the lowest priority.
  function automatic logic [CH_W:0] rrPick(input logic [NUM_CH-1:0] req,
                                           input logic [CH_W-1:0]   last);
    logic [CH_W:0]   result;
    logic [CH_W-1:0] idx;
    result = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = last + CH_W'(i);
      if (req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

endpackage

// File: rtl/temp_sensor_scheduler_if.sv
// Sensor request/acknowledge and result bus between the scheduler (slave)
// and its environment (master).
interface temp_sensor_scheduler_if;
  import temp_sensor_scheduler_pkg::*;

  logic [NUM_CH-1:0]          sns_req;
  logic [NUM_CH*SENSOR_W-1:0] sns_val;
  logic [NUM_CH-1:0]          sns_ack;
  logic [BASE_W-1:0]          base_temp;
  logic [TEMP_W-1:0]          alarm_thresh;
  logic [TEMP_W-1:0]          temp_out;
  logic [CH_W-1:0]            temp_ch;
  logic                       temp_valid;
  logic                       busy;
  logic [NUM_CH-1:0]          alarm;

  modport master (
    output sns_req, sns_val, base_temp, alarm_thresh,
    input  sns_ack, temp_out, temp_ch, temp_valid, busy, alarm
  );

  modport slave (
    input  sns_req, sns_val, base_temp, alarm_thresh,
    output sns_ack, temp_out, temp_ch, temp_valid, busy, alarm
  );

endinterface

// File: rtl/temp_sensor_scheduler_mul.sv
// temp_shift_add_mul: sequential shift-add multiplier, one multiplier bit
// per cycle, LSB first. Operands are captured on start; done is high
// during the cycle whose closing edge performs the final step, so product
// is complete right after that edge and holds until the next start.
module temp_shift_add_mul
  import temp_sensor_scheduler_pkg::*;
#(
  parameter int W = SENSOR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CNT_W = $clog2(W);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] count;
  logic           running;

  assign done    = running && (count == CNT_W'(W - 1));
  assign product = acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= {{W{1'b0}}, a};
      acc     <= '0;
      mplier  <= b;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/temp_sensor_scheduler.sv
// temp_sensor_scheduler: round-robin scheduler for four 4-bit temperature
// sensors. Each granted sample is squared by a shift-add multiplier,
// scaled by SHIFT and offset by base_temp, yielding one result per six
// cycles. Optional per-channel over-temperature alarm with hysteresis is
// built only when the macro TEMP_ALARM_EN is defined.
module temp_sensor_scheduler
  import temp_sensor_scheduler_pkg::*;
#(
  parameter int SHIFT      = DEFAULT_SHIFT,
  parameter int ALARM_HYST = DEFAULT_ALARM_HYST
) (
  input logic                    clk,
  input logic                    rst_n,
  temp_sensor_scheduler_if.slave bus
);

  stateT state, nextState;

  logic                  grant;
  logic                  loadResult;
  logic                  mulDone;
  logic                  pickFound;
  logic [CH_W-1:0]       pickIdx;
  logic [CH_W-1:0]       lastServed;
  logic [CH_W-1:0]       curCh;
  logic [SENSOR_W-1:0]   pickVal;
  logic [2*SENSOR_W-1:0] product;
  logic [TEMP_W-1:0]     newTemp;

  assign {pickFound, pickIdx} = rrPick(bus.sns_req, lastServed);
  assign pickVal = bus.sns_val[pickIdx*SENSOR_W +: SENSOR_W];
  assign newTemp = TEMP_W'(bus.base_temp) + TEMP_W'(product >> SHIFT);

  temp_shift_add_mul #(.W(SENSOR_W)) mulInst (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (grant),
    .a       (pickVal),
    .b       (pickVal),
    .product (product),
    .done    (mulDone)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: wait for any request, run the multiply, then one add cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|bus.sns_req) nextState = MUL;
      MUL:     if (mulDone) nextState = ADD;
      ADD:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs: requests are only looked at while idle.
  always_comb begin
    bus.busy   = (state != IDLE);
    grant      = (state == IDLE) && pickFound;
    loadResult = (state == ADD);
  end

  // Grant bookkeeping, one-cycle ack, and the registered result with its valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sns_ack    <= '0;
      bus.temp_valid <= 1'b0;
      bus.temp_out   <= '0;
      bus.temp_ch    <= '0;
      lastServed     <= CH_W'(NUM_CH - 1);
      curCh          <= '0;
    end else begin
      bus.sns_ack    <= grant ? (NUM_CH'(1) << pickIdx) : '0;
      bus.temp_valid <= loadResult;
      if (grant) begin
        curCh      <= pickIdx;
        lastServed <= pickIdx;
      end
      if (loadResult) begin
        bus.temp_out <= newTemp;
        bus.temp_ch  <= curCh;
      end
    end
  end

`ifdef TEMP_ALARM_EN
  logic [NUM_CH-1:0] alarmReg;
  logic [TEMP_W-1:0] clearLevel;

  assign clearLevel = (bus.alarm_thresh > TEMP_W'(ALARM_HYST)) ?
                      (bus.alarm_thresh - TEMP_W'(ALARM_HYST)) : '0;
  assign bus.alarm  = alarmReg;

  // Set at or above threshold, clear below threshold minus hysteresis, else hold; only the served channel moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarmReg <= '0;
    end else if (loadResult) begin
      if (newTemp >= bus.alarm_thresh) alarmReg[curCh] <= 1'b1;
      else if (newTemp < clearLevel)   alarmReg[curCh] <= 1'b0;
    end
  end
`else
  assign bus.alarm = '0;
`endif

endmodule

// File: tb/tb_temp_sensor_scheduler.sv
// Self-checking bench for temp_sensor_scheduler. Directed scenarios plus a
// randomized run compared against a transaction-level reference model.
// Alarm expectations follow the TEMP_ALARM_EN macro.
module tb_temp_sensor_scheduler;

  localparam int SHIFT = 3;
  localparam int HYST  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   testsRun    = 0;
  int   testsFailed = 0;

  temp_sensor_scheduler_if bus();

  temp_sensor_scheduler #(.SHIFT(SHIFT), .ALARM_HYST(HYST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int expTemp(input int base, input int v);
    return (base + ((v * v) >> SHIFT)) % 256;
  endfunction

  function automatic int ackIndex(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input logic [3:0] reqDuring);
    rst_n            = 1'b0;
    bus.sns_req      = reqDuring;
    bus.sns_val      = '0;
    bus.base_temp    = '0;
    bus.alarm_thresh = 8'hFF;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one request on a single channel and wait (bounded) for its result.
  task automatic runOne(input int ch, input int v, input int base,
                        output logic [3:0] ackSeen, output bit seen);
    bus.base_temp          = 5'(base);
    bus.sns_val[4*ch +: 4] = 4'(v);
    bus.sns_req            = 4'(1 << ch);
    tick();
    ackSeen     = bus.sns_ack;
    bus.sns_req = '0;
    seen        = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (bus.temp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.sns_req      = '0;
    bus.sns_val      = 16'hFFFF;
    bus.base_temp    = 5'd31;
    bus.alarm_thresh = 8'd0;
    tick();
    tick();
    testsRun++;
    if ({bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm} !== 20'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: got ack=%b valid=%b busy=%b temp=%0d ch=%0d alarm=%b, expected all zero",
               bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm);
    end
    rst_n            = 1'b1;
    bus.alarm_thresh = 8'hFF;
    tick();
    testsRun++;
    if (bus.busy !== 1'b0 || bus.sns_ack !== 4'b0) begin
      testsFailed++;
      $display("[TB] FAIL idle_no_request: got busy=%b ack=%b, expected busy=0 ack=0000", bus.busy, bus.sns_ack);
    end
  endtask

  task automatic test_single();
    int edges;
    bit seen;
    bus.base_temp    = 5'd20;
    bus.sns_val      = 16'h0009;
    bus.sns_req      = 4'b0001;
    tick();
    testsRun++;
    if (bus.sns_ack !== 4'b0001 || bus.busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_grant: got ack=%b busy=%b, expected ack=0001 busy=1", bus.sns_ack, bus.busy);
    end
    bus.sns_req = '0;
    tick();
    testsRun++;
    if (bus.sns_ack !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL single_ack_pulse: got ack=%b, expected 0000", bus.sns_ack);
    end
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      edges++;
      if (bus.temp_valid === 1'b1) seen = 1'b1;
    end
    testsRun++;
    if (!seen || edges != 5) begin
      testsFailed++;
      $display("[TB] FAIL single_latency: got seen=%0d edges=%0d, expected valid 5 edges after grant", seen, edges);
    end
    testsRun++;
    if (bus.temp_out !== 8'd30 || bus.temp_ch !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL single_result: got temp=%0d ch=%0d, expected temp=30 ch=0", bus.temp_out, bus.temp_ch);
    end
    tick();
    tick();
    testsRun++;
    if (bus.temp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.temp_out !== 8'd30 || bus.temp_ch !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL single_hold: got valid=%b busy=%b temp=%0d ch=%0d, expected 0 0 30 0",
               bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch);
    end
  endtask

  task automatic test_extremes();
    int bases[2];
    int vals[2];
    int chs[2];
    int exps[2];
    logic [3:0] ackSeen;
    bit seen;
    bases = '{31, 0};
    vals  = '{15, 0};
    chs   = '{3, 1};
    exps  = '{59, 0};
    bus.sns_val = 16'($urandom);
    for (int k = 0; k < 2; k++) begin
      runOne(chs[k], vals[k], bases[k], ackSeen, seen);
      testsRun++;
      if (!seen || ackSeen !== 4'(1 << chs[k]) || bus.temp_out !== 8'(exps[k]) || bus.temp_ch !== 2'(chs[k])) begin
        testsFailed++;
        $display("[TB] FAIL extreme_%0d: got seen=%0d ack=%b temp=%0d ch=%0d, expected ack=%b temp=%0d ch=%0d",
                 k, seen, ackSeen, bus.temp_out, bus.temp_ch, 4'(1 << chs[k]), exps[k], chs[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int ackCh[$];
    int ackCyc[$];
    int validCyc[$];
    int validCh[$];
    int validTemp[$];
    int expOrder[6];
    logic [15:0] vals;
    int base;
    expOrder = '{0, 1, 2, 3, 0, 2};
    applyReset(4'b1111);
    vals          = 16'($urandom);
    base          = int'($urandom_range(0, 31));
    bus.sns_val   = vals;
    bus.base_temp = 5'(base);
    for (int cyc = 0; cyc < 80 && validCyc.size() < 6; cyc++) begin
      tick();
      if (bus.sns_ack !== 4'b0000) begin
        ackCh.push_back(ackIndex(bus.sns_ack));
        ackCyc.push_back(cyc);
        bus.sns_req = bus.sns_req & ~bus.sns_ack;
        if (ackCh.size() == 4) bus.sns_req = bus.sns_req | 4'b0101;
      end
      if (bus.temp_valid === 1'b1) begin
        validCyc.push_back(cyc);
        validCh.push_back(int'(bus.temp_ch));
        validTemp.push_back(int'(bus.temp_out));
      end
    end
    bus.sns_req = '0;
    testsRun++;
    if (ackCh.size() != 6 || validCyc.size() != 6) begin
      testsFailed++;
      $display("[TB] FAIL rr_counts: got acks=%0d results=%0d, expected 6 and 6", ackCh.size(), validCyc.size());
    end
    for (int i = 0; i < 6 && i < ackCh.size(); i++) begin
      testsRun++;
      if (ackCh[i] != expOrder[i]) begin
        testsFailed++;
        $display("[TB] FAIL rr_order_%0d: got ch=%0d, expected ch=%0d", i, ackCh[i], expOrder[i]);
      end
    end
    for (int i = 1; i < ackCyc.size() && i < validCyc.size(); i++) begin
      testsRun++;
      if (ackCyc[i] - ackCyc[i-1] != 6 || validCyc[i] - validCyc[i-1] != 6) begin
        testsFailed++;
        $display("[TB] FAIL rr_spacing_%0d: got ack gap=%0d valid gap=%0d, expected 6 and 6",
                 i, ackCyc[i] - ackCyc[i-1], validCyc[i] - validCyc[i-1]);
      end
    end
    for (int i = 0; i < 6 && i < validCyc.size() && i < ackCyc.size(); i++) begin
      testsRun++;
      if (validCyc[i] - ackCyc[i] != 5 || validCh[i] != expOrder[i] ||
          validTemp[i] != expTemp(base, int'((vals >> (4 * expOrder[i])) & 16'hF))) begin
        testsFailed++;
        $display("[TB] FAIL rr_result_%0d: got delay=%0d ch=%0d temp=%0d, expected delay=5 ch=%0d temp=%0d",
                 i, validCyc[i] - ackCyc[i], validCh[i], validTemp[i], expOrder[i],
                 expTemp(base, int'((vals >> (4 * expOrder[i])) & 16'hF)));
      end
    end
  endtask

  task automatic test_alarm();
    logic [3:0] ackSeen;
    bit seen;
`ifdef TEMP_ALARM_EN
    int temps[4];
    int a;
    int clearLvl;
    temps = '{30, 29, 28, 27};
    applyReset(4'b0000);
    bus.alarm_thresh = 8'd30;
    a        = 0;
    clearLvl = (30 > HYST) ? 30 - HYST : 0;
    for (int k = 0; k < 4; k++) begin
      runOne(1, 0, temps[k], ackSeen, seen);
      if (temps[k] >= 30) a = 1;
      else if (temps[k] < clearLvl) a = 0;
      testsRun++;
      if (!seen || bus.temp_out !== 8'(temps[k]) || bus.alarm !== 4'(a << 1)) begin
        testsFailed++;
        $display("[TB] FAIL alarm_step_%0d: got seen=%0d temp=%0d alarm=%b, expected temp=%0d alarm=%b",
                 k, seen, bus.temp_out, bus.alarm, temps[k], 4'(a << 1));
      end
    end
`else
    applyReset(4'b0000);
    bus.alarm_thresh = 8'd0;
    runOne(2, 15, 31, ackSeen, seen);
    testsRun++;
    if (!seen || bus.alarm !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL alarm_disabled: got seen=%0d alarm=%b, expected alarm=0000", seen, bus.alarm);
    end
`endif
    bus.alarm_thresh = 8'hFF;
  endtask

  task automatic test_reset_midop();
    logic [3:0] ackSeen;
    bit seen;
    int acks[$];
    int strayValid;
    applyReset(4'b0000);
    runOne(3, 15, 31, ackSeen, seen);
    bus.sns_val[7:4] = 4'd12;
    bus.sns_req      = 4'b0010;
    tick();
    bus.sns_req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm} !== 20'd0) begin
      testsFailed++;
      $display("[TB] FAIL midop_reset_values: got ack=%b valid=%b busy=%b temp=%0d ch=%0d alarm=%b, expected all zero",
               bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm);
    end
    bus.sns_req = 4'b0101;
    tick();
    tick();
    rst_n      = 1'b1;
    strayValid = 0;
    for (int i = 0; i < 30 && acks.size() < 2; i++) begin
      tick();
      if (bus.temp_valid === 1'b1 && acks.size() == 0) strayValid++;
      if (bus.sns_ack !== 4'b0000) begin
        acks.push_back(ackIndex(bus.sns_ack));
        bus.sns_req = bus.sns_req & ~bus.sns_ack;
      end
    end
    bus.sns_req = '0;
    testsRun++;
    if (acks.size() != 2 || acks[0] != 0 || acks[1] != 2 || strayValid != 0) begin
      testsFailed++;
      $display("[TB] FAIL midop_recovery: got acks=%0d first=%0d second=%0d stray_valid=%0d, expected 2 acks ch0 then ch2, stray_valid=0",
               acks.size(), (acks.size() > 0) ? acks[0] : -1, (acks.size() > 1) ? acks[1] : -1, strayValid);
    end
  endtask

  task automatic test_ignore_inputs();
    bit seen;
    int sawAck;
    applyReset(4'b0000);
    bus.base_temp = 5'd10;
    bus.sns_val   = 16'h0075;
    bus.sns_req   = 4'b0011;
    tick();
    testsRun++;
    if (bus.sns_ack !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL ignore_grant: got ack=%b, expected 0001", bus.sns_ack);
    end
    bus.sns_req   = 4'b0000;
    bus.sns_val   = 16'h00FF;
    bus.base_temp = 5'd12;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (bus.temp_valid === 1'b1) seen = 1'b1;
    end
    testsRun++;
    if (!seen || bus.temp_out !== 8'(expTemp(12, 5)) || bus.temp_ch !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_result: got seen=%0d temp=%0d ch=%0d, expected temp=%0d ch=0",
               seen, bus.temp_out, bus.temp_ch, expTemp(12, 5));
    end
    sawAck = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sns_ack !== 4'b0000 || bus.busy !== 1'b0) sawAck++;
    end
    testsRun++;
    if (sawAck != 0) begin
      testsFailed++;
      $display("[TB] FAIL ignore_dropped_req: got %0d active cycles, expected 0", sawAck);
    end
  endtask

  task automatic test_random();
    int mK, mLast, mCh, mVal, c, clearLvl;
    logic [7:0]  eTemp, thresh;
    logic [1:0]  eCh;
    logic [3:0]  eAck, eAlarm, req;
    logic        eValid, eBusy;
    logic [15:0] val;
    logic [4:0]  base;
    applyReset(4'b0000);
    mK = -1; mLast = 3; mCh = 0; mVal = 0;
    eTemp = '0; eCh = '0; eAlarm = '0; req = '0;
    thresh           = 8'($urandom_range(10, 50));
    bus.alarm_thresh = thresh;
    clearLvl         = (int'(thresh) > HYST) ? int'(thresh) - HYST : 0;
    for (int n = 0; n < 300; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (!req[b] && $urandom_range(0, 3) == 0) req[b] = 1'b1;
        else if (req[b] && $urandom_range(0, 15) == 0) req[b] = 1'b0;
      end
      val           = 16'($urandom);
      base          = 5'($urandom);
      bus.sns_req   = req;
      bus.sns_val   = val;
      bus.base_temp = base;
      tick();
      eAck   = '0;
      eValid = 1'b0;
      if (mK >= 0) begin
        mK++;
        if (mK == 5) begin
          eTemp  = 8'(expTemp(int'(base), mVal));
          eCh    = 2'(mCh);
          eValid = 1'b1;
          mK     = -1;
`ifdef TEMP_ALARM_EN
          if (int'(eTemp) >= int'(thresh)) eAlarm[mCh] = 1'b1;
          else if (int'(eTemp) < clearLvl) eAlarm[mCh] = 1'b0;
`endif
        end
      end else if (req != 4'b0000) begin
        for (int i = 1; i <= 4; i++) begin
          c = (mLast + i) % 4;
          if (req[c]) begin
            mCh = c;
            break;
          end
        end
        mLast = mCh;
        mVal  = int'((val >> (4 * mCh)) & 16'hF);
        mK    = 0;
        eAck  = 4'(1 << mCh);
      end
      eBusy = (mK >= 0);
      testsRun++;
      if ({bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm} !==
          {eAck, eValid, eBusy, eTemp, eCh, eAlarm}) begin
        testsFailed++;
        $display("[TB] FAIL random_cycle_%0d: got ack=%b valid=%b busy=%b temp=%0d ch=%0d alarm=%b, expected ack=%b valid=%b busy=%b temp=%0d ch=%0d alarm=%b",
                 n, bus.sns_ack, bus.temp_valid, bus.busy, bus.temp_out, bus.temp_ch, bus.alarm,
                 eAck, eValid, eBusy, eTemp, eCh, eAlarm);
      end
      req = req & ~bus.sns_ack;
    end
    bus.sns_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_round_robin();
    test_alarm();
    test_reset_midop();
    test_ignore_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion after 1000000 time units, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
